// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the mult/div sequencer: FSM states and rstatus codes.
// The exception-code helper keeps the mul/div code selection in one place.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? RSTATUS_DIV : RSTATUS_MUL;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_cycle_counter.sv
// Cycle counter used to bound how long the shared core may stay busy.
// hit flags the last allowed BUSY cycle.
module md_cycle_counter #(
  parameter int CNT_W      = 6,
  parameter int MAX_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Issues mul/div operations from DX to the shared multi-cycle core, stalls the
// front of the pipeline while it runs, and hands the result to DX/XM for one cycle.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dx_valid,
  input  logic             dx_is_mul,
  input  logic             dx_is_div,
  input  logic [WIDTH-1:0] dx_a,
  input  logic [WIDTH-1:0] dx_b,
  input  logic [4:0]       dx_rd,
  input  logic             flush,
  input  logic             core_ready,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_exc,
  output logic             core_mult,
  output logic             core_div,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic             stall,
  output logic             md_done,
  output logic [WIDTH-1:0] md_result,
  output logic             md_exc,
  output logic [31:0]      md_exc_code,
  output logic [4:0]       md_rd
);

  md_state_t        state_q, state_d;
  logic             op_div_q, op_div_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0]       rd_q, rd_d;
  logic             mult_q, mult_d, div_q, div_d;
  logic             exc_q, exc_d;
  logic [31:0]      code_q, code_d;
  logic             issue, hit;

  assign issue = (state_q == ST_IDLE) && dx_valid && (dx_is_mul || dx_is_div) && !flush;

  md_cycle_counter #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_BUSY),
    .enable (state_q == ST_BUSY),
    .hit    (hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      code_q   <= code_d;
    end
  end

  // Divide-by-zero never reaches the core; BUSY exits favour flush, then ready, then timeout.
  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    mult_d   = 1'b0;
    div_d    = 1'b0;
    res_d    = res_q;
    exc_d    = exc_q;
    code_d   = code_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          rd_d     = dx_rd;
          op_div_d = dx_is_div;
          if (dx_is_div && (dx_b == '0)) begin
            res_d   = '0;
            exc_d   = 1'b1;
            code_d  = RSTATUS_DIV;
            state_d = ST_DONE;
          end else begin
            a_d     = dx_a;
            b_d     = dx_b;
            mult_d  = !dx_is_div;
            div_d   = dx_is_div;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (core_ready) begin
          res_d   = core_exc ? '0 : core_result;
          exc_d   = core_exc;
          code_d  = core_exc ? exc_code(op_div_q) : 32'd0;
          state_d = ST_DONE;
        end else if (hit) begin
          res_d   = '0;
          exc_d   = 1'b1;
          code_d  = exc_code(op_div_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall       = issue || (state_q == ST_BUSY);
  assign md_done     = (state_q == ST_DONE);
  assign core_mult   = mult_q;
  assign core_div    = div_q;
  assign core_a      = a_q;
  assign core_b      = b_q;
  assign md_result   = res_q;
  assign md_exc      = exc_q;
  assign md_exc_code = code_q;
  assign md_rd       = rd_q;

endmodule
